// File: rtl/vga_if.sv
// Pixel-side bundle between the raster timing stage and the colour logic / DAC pins.
// The timing stage is the master: it drives coordinates and pins, and receives colour.
interface vga_if;
    logic [23:0] vga_data;
    logic [9:0]  vga_xide;
    logic [9:0]  vga_yide;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [23:0] vga_rgb;
    logic        frame_start;

    modport master (
        input  vga_data,
        output vga_xide, vga_yide, vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );

    modport slave (
        output vga_data,
        input  vga_xide, vga_yide, vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );
endinterface

// File: rtl/vga_timing_driver.sv
// Free-running raster timing with a one-stage output register; the colour returned
// for the presented coordinate lands on the pins together with its sync and enable.
module vga_timing_driver #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input logic   clk,
    input logic   rst,
    vga_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        rst_q;
    logic        hold;
    logic        active;
    logic        h_sync;
    logic        v_sync;

    // The raster sits at the origin for one extra clock after rst drops, so the
    // first frame_start reaches the pins two edges after release.
    assign hold = rst | rst_q;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (hold) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_comb begin
        active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        h_sync = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    assign vga.vga_xide = active ? h_cnt[9:0] : '0;
    assign vga.vga_yide = active ? v_cnt : '0;

    always_ff @(posedge clk) begin
        if (hold) begin
            vga.vga_hs      <= ~SYNC_POL;
            vga.vga_vs      <= ~SYNC_POL;
            vga.vga_de      <= 1'b0;
            vga.vga_rgb     <= '0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.vga_hs      <= h_sync ? SYNC_POL : ~SYNC_POL;
            vga.vga_vs      <= v_sync ? SYNC_POL : ~SYNC_POL;
            vga.vga_de      <= active;
            vga.vga_rgb     <= active ? vga.vga_data : 24'h0;
            vga.frame_start <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
        end
    end

endmodule

// File: doc/vga_timing_driver.md
# vga_timing_driver

Display-timing stage for the VGA game path. It generates 800x600@72 Hz raster timing from the 50 MHz system clock and presents the current pixel coordinate on `vga_xide`/`vga_yide` to the pixel-colour logic. It registers the 24-bit colour that logic returns, and drives the sync, data-enable and RGB pins with all signals aligned. It also emits a once-per-frame strobe for frame-synchronous game updates.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch, clocks
- `H_SYNC`, 120: horizontal sync width, clocks
- `H_BP`, 64: horizontal back porch, clocks
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch, lines
- `V_SYNC`, 6: vertical sync width, lines
- `V_BP`, 23: vertical back porch, lines
- `SYNC_POL`, 1: asserted level of `vga_hs`/`vga_vs`

Ports:
- `clk`  in  1  50 MHz system/pixel clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `vga_data`  in  24  colour for the pixel currently at `vga_xide`/`vga_yide`; combinational function of them
- `vga_xide`  out  10  current column, 0..H_ACTIVE-1; 0 outside active area
- `vga_yide`  out  10  current row, 0..V_ACTIVE-1; 0 outside active area
- `vga_hs`  out  1  horizontal sync, registered
- `vga_vs`  out  1  vertical sync, registered
- `vga_de`  out  1  data enable, registered
- `vga_rgb`  out  24  pixel colour to DAC, registered
- `frame_start`  out  1  one-clock pulse, registered

## Operation
- Counters:
  - `h_cnt` is 11 bits and counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1040.
  - `v_cnt` is 10 bits and counts 0..V_TOTAL-1, where V_TOTAL = 666.
  - `h_cnt` wraps to 0 after H_TOTAL-1.
  - `v_cnt` advances only on the clock where `h_cnt`==H_TOTAL-1, and wraps to 0 after V_TOTAL-1.
- Region order per axis: active, front porch, sync, back porch.
  - Horizontal: active is h_cnt 0..799, sync is h_cnt 856..975.
  - Vertical: active is v_cnt 0..599, sync is v_cnt 637..642.
- `active` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), combinational.
- `vga_xide`/`vga_yide` are combinational from the counters:
  - When `active`: `vga_xide` = h_cnt[9:0], `vga_yide` = v_cnt.
  - Otherwise: both are 0.
- Pipeline register, one stage; all outputs below update every clock:
  - `vga_hs` = SYNC_POL when h_cnt is in the sync range, else ~SYNC_POL.
  - `vga_vs` = SYNC_POL when v_cnt is in the sync range, else ~SYNC_POL. It changes on line boundaries only, co-timed with h_cnt = 0.
  - `vga_de` = `active`.
  - `vga_rgb` = `vga_data` when `active`, else 24'h0. Colour is forced black in blanking regardless of `vga_data`.
  - `frame_start` = 1 when h_cnt==0 && v_cnt==0, else 0.
- Reset values, applied on the clock edge where `rst`=1:
  - h_cnt=0, v_cnt=0.
  - `vga_hs`=`vga_vs`=~SYNC_POL.
  - `vga_de`=0, `vga_rgb`=0, `frame_start`=0.
  - Combinationally, `vga_xide`=`vga_yide`=0 while the counters are 0.
- Reset mid-frame: counters restart at 0 on the next edge with no partial-line completion. The raster restarts at pixel (0,0).
- `rst` held high: counters stay at 0 and outputs stay at reset values. There is no output pulse of `frame_start` while in reset.
- There are no inputs other than `vga_data`. Timing is free-running and unaffected by colour content.

## Timing
- Latency from coordinate to pin is exactly 1 clock. `vga_rgb`, `vga_de`, `vga_hs`, `vga_vs` and `frame_start` on clock N+1 correspond to counter state on clock N.
- First clock after reset release (rst low at edge E):
  - Counters are at (0,0) during the cycle after E.
  - `frame_start`=1, `vga_de`=1 and `vga_rgb`=`vga_data`@(0,0) appear after edge E+1.
- Line period is 1040 clocks. `vga_hs` is asserted for exactly 120 clocks per line, starting 856 clocks after `vga_de` rises.
- Frame period is 692,640 clocks, giving 72.19 Hz. `vga_vs` is asserted for exactly 6×1040 = 6240 clocks. `frame_start` occurs once per frame period.
- `vga_de` is high for 800 consecutive clocks on each of 600 lines per frame, 480,000 clocks total.

## Test plan
- **Reset:** assert `rst` for 5 clocks mid-frame. Required:
  - `vga_hs`=`vga_vs`=0, `vga_de`=0, `vga_rgb`=0, `frame_start`=0 and `vga_xide`=`vga_yide`=0 throughout.
  - `frame_start`=1 exactly 2 edges after `rst` falls.
- **Horizontal timing:** count clocks over 3 lines. Required:
  - `vga_de` high 800, then low 240, per line.
  - `vga_hs` rises 856 clocks after `vga_de` rises and stays high 120 clocks.
  - Line period 1040.
- **Vertical timing:** run 2 full frames. Required:
  - `frame_start` spacing is 692,640 clocks.
  - `vga_vs` high for 6240 clocks, starting 637×1040 clocks after `frame_start`.
  - 480,000 `vga_de` clocks per frame.
- **Colour alignment:** drive `vga_data` = {vga_yide[7:0], vga_xide[9:2], 8'hA5}. Required:
  - Each `vga_de`-high cycle shows `vga_rgb` equal to that function of the coordinate from one clock earlier.
  - Pixel (799,599) appears as `vga_rgb`=24'h57C7A5.
- **Blanking:** tie `vga_data`=24'hFFFFFF. Required: `vga_rgb`=0 whenever `vga_de`=0, and `vga_xide`=`vga_yide`=0 outside the active area.
- **Wrap:** observe the transition at h_cnt=1039, v_cnt=665. Required: the next coordinate is (0,0) and `frame_start` pulses for exactly 1 clock.
